text_line_pixel_gen: RTL and testbench

//   Downstream consumer of the 80-character text ROM: drives its character address, takes back
//   the 7-bit ASCII code, forms a font-ROM address for the current glyph row and serialises the
//   8-pixel glyph rows into one pixel per clock for the VGA colour stage.

---
 rtl/text_line_pixel_gen.sv | 172 +++++++++++++++++
 tb/tb_text_line_pixel_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_pixel_gen.sv
// Text-line pixel generator: fetches characters from the text ROM, looks up glyph rows in the
// font ROM and serialises them MSB-first, one pixel per clock, with the next glyph prefetched.
module text_line_pixel_gen #(
    parameter int unsigned NUM_CHARS = 80,
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned ROM_LAT   = 2,
    parameter int unsigned FONT_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [2:0]        i_glyph_row,
    output logic [6:0]        o_char_addr,
    input  logic [6:0]        i_char_code,
    output logic [9:0]        o_font_addr,
    input  logic [CHAR_W-1:0] i_font_row,
    output logic              o_pixel,
    output logic              o_pixel_valid,
    output logic              o_busy,
    output logic              o_line_done
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned PIX_W  = $clog2(CHAR_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHARS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(CHAR_W - 1);
    localparam logic [PIX_W-1:0]  PRE_LAT   = PIX_W'(ROM_LAT + FONT_LAT);

    if (ROM_LAT + FONT_LAT > CHAR_W - 1) begin : g_lat_err
        $error("ROM_LAT + FONT_LAT must not exceed CHAR_W - 1");
    end
    if (NUM_CHARS < 1 || NUM_CHARS > 128) begin : g_num_err
        $error("NUM_CHARS must be in 1..128");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_SHIFT    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              r_state,       w_state;
    logic [ROW_W-1:0]    r_glyph_row,   w_glyph_row;
    logic [ADDR_W-1:0]   r_char_addr,   w_char_addr;
    logic [ADDR_W-1:0]   r_char_idx,    w_char_idx;
    logic [PIX_W-1:0]    r_wait_cnt,    w_wait_cnt;
    logic [PIX_W-1:0]    r_pix_cnt,     w_pix_cnt;
    logic [CHAR_W-2:0]   r_shift,       w_shift;
    logic                r_pixel,       w_pixel;
    logic                r_pixel_valid, w_pixel_valid;
    logic                r_busy,        w_busy;
    logic                r_line_done,   w_line_done;
    logic [ADDR_W-1:0]   w_addr_step;

    // Prefetch address saturates at the last character instead of wrapping
    assign w_addr_step = (r_char_addr == LAST_ADDR) ? r_char_addr : r_char_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_glyph_row   <= '0;
            r_char_addr   <= '0;
            r_char_idx    <= '0;
            r_wait_cnt    <= '0;
            r_pix_cnt     <= '0;
            r_shift       <= '0;
            r_pixel       <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_line_done   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_glyph_row   <= w_glyph_row;
            r_char_addr   <= w_char_addr;
            r_char_idx    <= w_char_idx;
            r_wait_cnt    <= w_wait_cnt;
            r_pix_cnt     <= w_pix_cnt;
            r_shift       <= w_shift;
            r_pixel       <= w_pixel;
            r_pixel_valid <= w_pixel_valid;
            r_busy        <= w_busy;
            r_line_done   <= w_line_done;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_glyph_row   = r_glyph_row;
        w_char_addr   = r_char_addr;
        w_char_idx    = r_char_idx;
        w_wait_cnt    = r_wait_cnt;
        w_pix_cnt     = r_pix_cnt;
        w_shift       = r_shift;
        w_pixel       = r_pixel;
        w_pixel_valid = r_pixel_valid;
        w_busy        = r_busy;
        w_line_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_glyph_row = i_glyph_row;
                    w_char_addr = '0;
                    w_char_idx  = '0;
                    w_wait_cnt  = '0;
                    w_pix_cnt   = '0;
                    w_busy      = 1'b1;
                    w_state     = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                if (r_wait_cnt == PRE_LAT) begin
                    w_shift       = i_font_row[CHAR_W-2:0];
                    w_pixel       = i_font_row[CHAR_W-1];
                    w_pixel_valid = 1'b1;
                    w_char_addr   = w_addr_step;
                    w_pix_cnt     = '0;
                    w_state       = S_SHIFT;
                end else begin
                    w_wait_cnt = r_wait_cnt + PIX_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_pix_cnt != LAST_PIX) begin
                    w_shift   = {r_shift[CHAR_W-3:0], 1'b0};
                    w_pixel   = r_shift[CHAR_W-2];
                    w_pix_cnt = r_pix_cnt + PIX_W'(1);
                end else if (r_char_idx == LAST_ADDR) begin
                    w_shift       = '0;
                    w_pixel       = 1'b0;
                    w_pixel_valid = 1'b0;
                    w_busy        = 1'b0;
                    w_line_done   = 1'b1;
                    w_state       = S_DONE;
                end else begin
                    // Next glyph row has been waiting on i_font_row since mid-character
                    w_shift     = i_font_row[CHAR_W-2:0];
                    w_pixel     = i_font_row[CHAR_W-1];
                    w_pix_cnt   = '0;
                    w_char_idx  = r_char_idx + ADDR_W'(1);
                    w_char_addr = w_addr_step;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (i_abort && (r_state != S_IDLE)) begin
            w_state       = S_IDLE;
            w_pixel       = 1'b0;
            w_pixel_valid = 1'b0;
            w_busy        = 1'b0;
            w_line_done   = 1'b0;
        end
    end

    assign o_font_addr   = {i_char_code, r_glyph_row};
    assign o_char_addr   = r_char_addr;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;
    assign o_busy        = r_busy;
    assign o_line_done   = r_line_done;

endmodule

// File: tb/tb_text_line_pixel_gen.sv
// Bench for text_line_pixel_gen: text/font ROM models, pixel scoreboard, table of line scenarios
// plus hand sequences for reset, latency and a single-character build.
module tb_text_line_pixel_gen;

    localparam int NUM = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_start1 = 1'b0;
    logic       i_abort = 1'b0;
    logic [2:0] i_glyph_row = 3'd0;

    logic [6:0] char_addr, char_code = '0, addr_q = '0;
    logic [9:0] font_addr;
    logic [7:0] font_row = '0;
    logic       pixel, pixel_valid, busy, line_done;

    logic [6:0] char_addr1, char_code1 = '0, addr_q1 = '0;
    logic [9:0] font_addr1;
    logic [7:0] font_row1 = '0;
    logic       pixel1, pixel_valid1, busy1, line_done1;

    int         checks = 0;
    int         errors = 0;
    int         pix_seen = 0;
    logic [6:0] max_addr = '0;
    logic       q[$];

    always #5 clk = ~clk;

    function automatic logic [6:0] text_of(input int a);
        string s;
        s = "the quick brown fox jumps over the lazy dog ";
        return 7'(s[a % s.len()]);
    endfunction

    function automatic logic [7:0] font_of(input logic [6:0] c, input logic [2:0] r);
        logic [15:0] h;
        h = {9'd0, c} * 16'd29 + {13'd0, r} * 16'd113 + 16'h5A;
        return h[7:0] ^ {c[2:0], r, c[6:5]};
    endfunction

    // Text ROM registers address and data (2 clocks); font ROM is 1 clock
    always @(posedge clk) begin
        addr_q     <= char_addr;
        char_code  <= text_of(int'(addr_q));
        font_row   <= font_of(font_addr[9:3], font_addr[2:0]);
        addr_q1    <= char_addr1;
        char_code1 <= text_of(int'(addr_q1));
        font_row1  <= font_of(font_addr1[9:3], font_addr1[2:0]);
    end

    text_line_pixel_gen #(.NUM_CHARS(NUM)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_glyph_row(i_glyph_row), .o_char_addr(char_addr), .i_char_code(char_code),
        .o_font_addr(font_addr), .i_font_row(font_row), .o_pixel(pixel),
        .o_pixel_valid(pixel_valid), .o_busy(busy), .o_line_done(line_done)
    );

    text_line_pixel_gen #(.NUM_CHARS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start1), .i_abort(i_abort),
        .i_glyph_row(i_glyph_row), .o_char_addr(char_addr1), .i_char_code(char_code1),
        .o_font_addr(font_addr1), .i_font_row(font_row1), .o_pixel(pixel1),
        .o_pixel_valid(pixel_valid1), .o_busy(busy1), .o_line_done(line_done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and score any valid pixel against the queue
    task automatic tick();
        logic e;
        @(negedge clk);
        if (pixel_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_pixel actual=%0d required=none at %0t", pixel, $time);
            end else begin
                e = q.pop_front();
                if (pixel !== e) begin
                    errors++;
                    $display("FAIL pixel[%0d] actual=%0d required=%0d", pix_seen, pixel, e);
                end
            end
            pix_seen++;
        end
        if (char_addr > max_addr) max_addr = char_addr;
    endtask

    typedef struct {
        logic [2:0] row;
        int         xstart;    // pixel index at which a stray start is pulsed (0 = none)
        int         cut_at;    // pixel index at which the line is cut (0 = none)
        int         cut_kind;  // 1 abort, 2 async reset, 3 abort+start together
        bit         poke_done; // pulse start during the DONE cycle
    } vec_t;

    task automatic run_line(input vec_t v);
        int         first = -1;
        int         last = -1;
        int         c = 1;
        bit         done = 1'b0;
        logic [7:0] lr;
        q.delete();
        for (int k = 0; k < NUM; k++) begin
            lr = font_of(text_of(k), v.row);
            for (int b = 7; b >= 0; b--) q.push_back(lr[b]);
        end
        pix_seen = 0;
        max_addr = '0;
        i_glyph_row = v.row;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_glyph_row = v.row ^ 3'd5;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done && c < 1000) begin
            i_start = (v.xstart > 0 && pix_seen == v.xstart);
            if (v.cut_at > 0 && pix_seen == v.cut_at) begin
                if (v.cut_kind == 2) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_char_addr", 32'(char_addr), 32'd0);
                    tick();
                    rst_n = 1'b1;
                end else begin
                    i_abort = 1'b1;
                    i_start = (v.cut_kind == 3);
                    tick();
                    i_abort = 1'b0;
                    i_start = 1'b0;
                    chk("abort_pixel_valid", 32'(pixel_valid), 32'd0);
                    chk("abort_pixel", 32'(pixel), 32'd0);
                end
                chk("cut_busy", 32'(busy), 32'd0);
                q.delete();
                for (int i = 0; i < 12; i++) begin
                    tick();
                    if (line_done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 1'b0)
                        chk("cut_stays_idle", {29'd0, line_done, busy, pixel_valid}, 32'd0);
                end
                chk("cut_no_line_done", 32'(line_done), 32'd0);
                return;
            end
            tick();
            c++;
            if (c == 3) chk("font_addr_first", 32'(font_addr), 32'({text_of(0), v.row}));
            if (pixel_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
            end
            if (line_done === 1'b1) done = 1'b1;
        end
        i_start = 1'b0;
        if (!done) begin
            chk("line_timeout", 32'(done), 32'd1);
            return;
        end
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("pixel_count", 32'(pix_seen), 32'(NUM * 8));
        chk("first_pixel_latency", 32'(first), 32'd5);
        chk("contiguous_span", 32'(last - first + 1), 32'(NUM * 8));
        chk("done_after_last", 32'(c - last), 32'd1);
        chk("max_char_addr", 32'(max_addr), 32'(NUM - 1));
        chk("queue_drained", 32'(q.size()), 32'd0);
        i_start = v.poke_done;
        tick();
        i_start = 1'b0;
        chk("done_single_pulse", 32'(line_done), 32'd0);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t       v;
        logic [7:0] lr;
        int         n;
        vecs[0] = '{row: 3'd3, xstart: 0,   cut_at: 0,   cut_kind: 0, poke_done: 1'b0};
        vecs[1] = '{row: 3'd5, xstart: 100, cut_at: 0,   cut_kind: 0, poke_done: 1'b1};
        vecs[2] = '{row: 3'd0, xstart: 0,   cut_at: 200, cut_kind: 1, poke_done: 1'b0};
        vecs[3] = '{row: 3'd7, xstart: 0,   cut_at: 0,   cut_kind: 0, poke_done: 1'b0};
        vecs[4] = '{row: 3'd1, xstart: 0,   cut_at: 300, cut_kind: 2, poke_done: 1'b0};
        vecs[5] = '{row: 3'd6, xstart: 0,   cut_at: 150, cut_kind: 3, poke_done: 1'b0};
        vecs[6] = '{row: 3'd2, xstart: 0,   cut_at: 0,   cut_kind: 0, poke_done: 1'b0};

        // Reset held while start toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_start = ~i_start;
        end
        i_start = 1'b0;
        chk("reset_pixel", 32'(pixel), 32'd0);
        chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_line_done", 32'(line_done), 32'd0);
        chk("reset_char_addr", 32'(char_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_release", 32'(busy), 32'd0);

        // Abort while idle does nothing
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_line_done", 32'(line_done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_line(v);
            if (v.poke_done == 1'b0) tick();
        end

        // Single-character build: 8 pixels then line_done
        lr = font_of(text_of(0), 3'd2);
        n = 0;
        i_glyph_row = 3'd2;
        i_start1 = 1'b1;
        tick();
        i_start1 = 1'b0;
        for (int i = 0; i < 40 && line_done1 !== 1'b1; i++) begin
            tick();
            if (pixel_valid1 === 1'b1) begin
                chk("n1_pixel", 32'(pixel1), 32'(lr[7 - (n % 8)]));
                n++;
            end
        end
        chk("n1_line_done", 32'(line_done1), 32'd1);
        chk("n1_pixel_count", 32'(n), 32'd8);
        chk("n1_char_addr", 32'(char_addr1), 32'd0);
        chk("n1_busy", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
